sw_run_ctrl: RTL and testbench

Run-control and timebase stage sitting directly upstream of the stopwatch digit counter chain (seconds-units 0-9, seconds-tens 0-5, ...). Debounces the start/stop and clear buttons, samples the direction switch, runs the IDLE/RUN/PAUSE/DONE state machine and divides the system clock into a one-cycle count-enable tick. Drives the chain's enable, reverse and clear inputs. Consumes the chain's all-zero flag so that count-down stops at 00:00.

---
 rtl/sw_run_ctrl.sv | 154 +++++++++++++++
 tb/tb_sw_run_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_run_ctrl.sv
// Stopwatch run control: button conditioning, IDLE/RUN/PAUSE/DONE sequencing and the
// count-enable timebase feeding the digit counter chain.

module sw_run_ctrl_btn #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_press
);
    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_lvl;
    logic [DW-1:0] r_cnt;
    logic          r_press;
    logic          w_synced;

    assign w_synced = r_sync[1];
    assign o_press  = r_press;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync  <= '0;
            r_lvl   <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_raw};
            r_press <= 1'b0;
            if (w_synced == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_MAX) begin
                // Level accepted; only a rising acceptance is a press.
                r_lvl   <= w_synced;
                r_cnt   <= '0;
                r_press <= w_synced;
            end else begin
                r_cnt <= r_cnt + DW'(1);
            end
        end
    end
endmodule

module sw_run_ctrl #(
    parameter int TICK_DIV        = 50000000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn_start_stop,
    input  logic i_btn_clear,
    input  logic i_sw_reverse,
    input  logic i_cnt_zero,
    output logic o_tick,
    output logic o_reverse,
    output logic o_clr,
    output logic o_running,
    output logic o_done
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_pre, w_pre_nxt;
    logic          r_tick, w_tick_nxt;
    logic          r_clr, w_clr_nxt;
    logic          r_reverse, w_rev_nxt;
    logic          r_running, r_done;
    logic [1:0]    r_rev_sync;
    logic [1:0]    w_raw, w_press;
    logic          w_start_p, w_clear_p;

    assign w_raw     = {i_btn_clear, i_btn_start_stop};
    assign w_start_p = w_press[0];
    assign w_clear_p = w_press[1];

    for (genvar g = 0; g < 2; g++) begin : g_btn
        sw_run_ctrl_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_raw   (w_raw[g]),
            .o_press (w_press[g])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        w_tick_nxt  = 1'b0;
        w_clr_nxt   = 1'b0;
        w_rev_nxt   = r_reverse;
        if (r_state == S_IDLE || r_state == S_PAUSE)
            w_rev_nxt = r_rev_sync[1];
        if (w_clear_p) begin
            w_state_nxt = S_IDLE;
            w_pre_nxt   = '0;
            w_clr_nxt   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: if (w_start_p) begin
                    w_pre_nxt   = '0;
                    w_state_nxt = (r_reverse && i_cnt_zero) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    // A pause freezes the prescaler so resuming neither loses nor repeats a tick.
                    if (w_start_p) begin
                        w_state_nxt = S_PAUSE;
                    end else if (r_pre == PRE_MAX) begin
                        w_pre_nxt = '0;
                        if (r_reverse && i_cnt_zero) w_state_nxt = S_DONE;
                        else                         w_tick_nxt  = 1'b1;
                    end else begin
                        w_pre_nxt = r_pre + PW'(1);
                    end
                end
                S_PAUSE: if (w_start_p) w_state_nxt = S_RUN;
                S_DONE: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_pre      <= '0;
            r_tick     <= 1'b0;
            r_clr      <= 1'b0;
            r_reverse  <= 1'b0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_rev_sync <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pre      <= w_pre_nxt;
            r_tick     <= w_tick_nxt;
            r_clr      <= w_clr_nxt;
            r_reverse  <= w_rev_nxt;
            r_running  <= (w_state_nxt == S_RUN);
            r_done     <= (w_state_nxt == S_DONE);
            r_rev_sync <= {r_rev_sync[0], i_sw_reverse};
        end
    end

    assign o_tick    = r_tick;
    assign o_clr     = r_clr;
    assign o_reverse = r_reverse;
    assign o_running = r_running;
    assign o_done    = r_done;
endmodule

// File: tb/tb_sw_run_ctrl.sv
// Directed bench for sw_run_ctrl: tick/clr events are logged by a monitor and
// matched against expected cycle stamps queued by the stimulus.
module tb_sw_run_ctrl;
    localparam int TD = 5;
    localparam int DB = 4;

    logic clk = 1'b0, reset = 1'b1;
    logic btn_ss = 1'b0, btn_clr = 1'b0, sw_rev = 1'b0, cnt_zero = 1'b0;
    logic tick, reverse, clr, running, done;

    sw_run_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_btn_start_stop (btn_ss),
        .i_btn_clear      (btn_clr),
        .i_sw_reverse     (sw_rev),
        .i_cnt_zero       (cnt_zero),
        .o_tick           (tick),
        .o_reverse        (reverse),
        .o_clr            (clr),
        .o_running        (running),
        .o_done           (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tick_q[$], clr_q[$], exp_tick_q[$];
    int n_total = 0, n_pass = 0, n_bad_tick = 0, n_tick_clr = 0;

    always @(negedge clk) begin
        if (tick === 1'b1) tick_q.push_back(cyc);
        if (clr === 1'b1) clr_q.push_back(cyc);
        if (tick === 1'b1 && running !== 1'b1) n_bad_tick++;
        if (tick === 1'b1 && clr === 1'b1) n_tick_clr++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return tick;
            1:       return running;
            2:       return clr;
            3:       return done;
            default: return reverse;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int w, input logic v, input int bound, output int at);
        int k = 0;
        while (sig(w) !== v && k < bound) begin
            step(1);
            k++;
        end
        if (sig(w) !== v) chk({tag, "_timeout"}, {31'b0, sig(w)}, {31'b0, v});
        at = cyc;
    endtask

    task automatic ticks_check(input string tag);
        chk({tag, "_tick_cnt"}, tick_q.size(), exp_tick_q.size());
        while (tick_q.size() > 0 && exp_tick_q.size() > 0)
            chk({tag, "_tick_at"}, tick_q.pop_front(), exp_tick_q.pop_front());
        tick_q.delete();
        exp_tick_q.delete();
    endtask

    task automatic do_clear();
        int c;
        btn_clr = 1'b1;
        wait_for("clear_seen", 2, 1'b1, 30, c);
        btn_clr = 1'b0;
        step(8);
    endtask

    initial begin
        int t0, t1, r, r2, p, c, d;
        // reset state
        step(3);
        chk("rst_tick", {31'b0, tick}, 0);
        chk("rst_clr", {31'b0, clr}, 0);
        chk("rst_running", {31'b0, running}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_reverse", {31'b0, reverse}, 0);
        reset = 1'b0;
        step(2);

        // 1: start from IDLE, tick every TD cycles
        tick_q.delete();
        t0 = cyc;
        btn_ss = 1'b1;
        wait_for("t1_run", 1, 1'b1, 30, r);
        chk("t1_run_latency", r, t0 + 7);
        step(3);
        btn_ss = 1'b0;
        exp_tick_q.push_back(r + 5);
        exp_tick_q.push_back(r + 10);
        exp_tick_q.push_back(r + 15);
        step(r + 17 - cyc);
        ticks_check("t1");
        chk("t1_still_running", {31'b0, running}, 1);

        // 2: clear glitch ignored, long clear accepted
        clr_q.delete();
        btn_clr = 1'b1;
        step(2);
        btn_clr = 1'b0;
        step(10);
        chk("t2_glitch_no_clr", clr_q.size(), 0);
        chk("t2_glitch_running", {31'b0, running}, 1);
        t0 = cyc;
        btn_clr = 1'b1;
        wait_for("t2_clr", 2, 1'b1, 30, c);
        chk("t2_clr_latency", c, t0 + 7);
        chk("t2_clr_idle", {31'b0, running}, 0);
        tick_q.delete();
        step(1);
        chk("t2_clr_width", {31'b0, clr}, 0);
        btn_clr = 1'b0;
        step(12);
        chk("t2_no_tick_idle", tick_q.size(), 0);
        chk("t2_one_clr", clr_q.size(), 1);

        // 3: pause at prescaler 3, resume keeps phase
        tick_q.delete();
        t0 = cyc;
        btn_ss = 1'b1;
        wait_for("t3_run", 1, 1'b1, 30, r);
        btn_ss = 1'b0;
        step(r + 7 - cyc);
        btn_ss = 1'b1;
        wait_for("t3_pause", 1, 1'b0, 30, p);
        chk("t3_pause_at", p, r + 14);
        btn_ss = 1'b0;
        exp_tick_q.push_back(r + 5);
        exp_tick_q.push_back(r + 10);
        step(20);
        t1 = cyc;
        btn_ss = 1'b1;
        wait_for("t3_resume", 1, 1'b1, 30, r2);
        chk("t3_resume_latency", r2, t1 + 7);
        btn_ss = 1'b0;
        exp_tick_q.push_back(r2 + 2);
        exp_tick_q.push_back(r2 + 7);
        step(r2 + 9 - cyc);
        ticks_check("t3");
        do_clear();

        // 4: count-down expiry
        sw_rev = 1'b1;
        step(3);
        chk("t4_rev_latched", {31'b0, reverse}, 1);
        tick_q.delete();
        btn_ss = 1'b1;
        wait_for("t4_run", 1, 1'b1, 30, r);
        btn_ss = 1'b0;
        exp_tick_q.push_back(r + 5);
        exp_tick_q.push_back(r + 10);
        exp_tick_q.push_back(r + 15);
        step(r + 16 - cyc);
        cnt_zero = 1'b1;
        wait_for("t4_done", 3, 1'b1, 30, d);
        chk("t4_done_at", d, r + 20);
        chk("t4_done_not_running", {31'b0, running}, 0);
        ticks_check("t4");
        btn_ss = 1'b1;
        step(8);
        btn_ss = 1'b0;
        step(8);
        chk("t4_start_ignored_done", {31'b0, done}, 1);
        chk("t4_start_ignored_run", {31'b0, running}, 0);
        chk("t4_no_tick_done", tick_q.size(), 0);
        do_clear();
        chk("t4_clear_done", {31'b0, done}, 0);
        // start from IDLE already at zero while counting down
        t0 = cyc;
        btn_ss = 1'b1;
        wait_for("t4_idle_done", 3, 1'b1, 30, d);
        chk("t4_idle_done_at", d, t0 + 7);
        chk("t4_idle_done_running", {31'b0, running}, 0);
        btn_ss = 1'b0;
        do_clear();
        cnt_zero = 1'b0;
        chk("t4_idle_done_cleared", {31'b0, done}, 0);

        // 5: direction frozen in RUN, reloaded in PAUSE
        sw_rev = 1'b0;
        step(3);
        chk("t5_rev_idle", {31'b0, reverse}, 0);
        btn_ss = 1'b1;
        wait_for("t5_run", 1, 1'b1, 30, r);
        btn_ss = 1'b0;
        sw_rev = 1'b1;
        step(8);
        chk("t5_rev_frozen", {31'b0, reverse}, 0);
        btn_ss = 1'b1;
        wait_for("t5_pause", 1, 1'b0, 30, p);
        btn_ss = 1'b0;
        step(3);
        chk("t5_rev_pause", {31'b0, reverse}, 1);
        do_clear();
        sw_rev = 1'b0;
        step(3);
        chk("t5_rev_back", {31'b0, reverse}, 0);

        // 6: simultaneous start+clear, then reset on a tick cycle
        btn_ss = 1'b1;
        wait_for("t6_run", 1, 1'b1, 30, r);
        btn_ss = 1'b0;
        step(8);
        clr_q.delete();
        t0 = cyc;
        btn_ss = 1'b1;
        btn_clr = 1'b1;
        wait_for("t6_clr", 2, 1'b1, 30, c);
        chk("t6_clr_latency", c, t0 + 7);
        chk("t6_clr_idle", {31'b0, running}, 0);
        btn_ss = 1'b0;
        btn_clr = 1'b0;
        step(10);
        chk("t6_start_discarded", {31'b0, running}, 0);
        chk("t6_one_clr", clr_q.size(), 1);
        sw_rev = 1'b1;
        step(3);
        btn_ss = 1'b1;
        wait_for("t6_run2", 1, 1'b1, 30, r);
        btn_ss = 1'b0;
        chk("t6_rev_before_reset", {31'b0, reverse}, 1);
        tick_q.delete();
        step(4);
        reset = 1'b1;
        step(1);
        chk("t6_rst_tick", {31'b0, tick}, 0);
        chk("t6_rst_running", {31'b0, running}, 0);
        chk("t6_rst_clr", {31'b0, clr}, 0);
        chk("t6_rst_done", {31'b0, done}, 0);
        chk("t6_rst_reverse", {31'b0, reverse}, 0);
        sw_rev = 1'b0;
        step(2);
        reset = 1'b0;
        step(3);
        chk("t6_after_rst_running", {31'b0, running}, 0);
        chk("t6_no_tick_after_rst", tick_q.size(), 0);

        chk("inv_tick_outside_run", n_bad_tick, 0);
        chk("inv_tick_with_clr", n_tick_clr, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
